// File: rtl/uart_regs_pkg.sv
// Register map, CON bit positions and sequencer states shared by the UART bus master
// and its holding-register sub-block.
package uart_regs_pkg;

    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    localparam int CON0_BIT      = 0;
    localparam int CON1_BIT      = 1;
    localparam int CON2_BIT      = 2;
    localparam int CON3_BIT      = 3;
    localparam int TX_STATUS_BIT = 4;

    // CON1 enables the RX-ready flag; CON0 stays clear.
    localparam logic [31:0] CON_INIT = 32'h0000_0002;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_GAP   = 3'd1,
        ST_POLL  = 3'd2,
        ST_RX_RD = 3'd3,
        ST_TX_WR = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_byte_buf.sv
// One-entry 8-bit holding register; a load and a clear in the same cycle leave it
// full with the new byte.
module uart_byte_buf
    import uart_regs_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       clear,
    output logic       full,
    output logic [7:0] data
);

    // Entry state: load has priority over clear.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            full <= 1'b0;
            data <= 8'h00;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (clear) begin
            full <= 1'b0;
        end else begin
            full <= full;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Bus initiator for the memory-mapped UART: turns a byte stream into TXD writes and
// polled RXD reads back into a byte stream.
module uart_bus_master
    import uart_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
    parameter int          HOLDOFF   = 4,
    parameter int          POLL_GAP  = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy
);

    localparam int CNT_W = cnt_width(HOLDOFF, POLL_GAP);
    localparam logic [31:0] TXD_ADDR = BASE_ADDR + TXD_OFS;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + RXD_OFS;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + CON_OFS;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(POLL_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    // With no idle gap configured, finishing an operation goes straight to the next poll.
    localparam state_t AFTER_OP = (POLL_GAP == 0) ? ST_POLL : ST_GAP;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             tx_full_s;
    logic [7:0]       tx_byte_s;
    logic             rx_full_s;
    logic [7:0]       rx_byte_s;
    logic             tx_load_s;
    logic             tx_clear_s;
    logic             rx_load_s;
    logic             rx_pop_s;
    logic             unused_rdata_s;

    assign tx_load_s      = tx_valid & ~tx_full_s;
    assign tx_clear_s     = (state_r == ST_TX_WR);
    assign rx_load_s      = (state_r == ST_RX_RD);
    assign rx_pop_s       = rx_full_s & rx_ready;
    assign tx_ready       = ~tx_full_s;
    assign rx_valid       = rx_full_s;
    assign rx_data        = rx_byte_s;
    assign unused_rdata_s = ^rdata[31:8];

    uart_byte_buf u_tx_buf (
        .CLK       (CLK),
        .Reset     (Reset),
        .load      (tx_load_s),
        .load_data (tx_data),
        .clear     (tx_clear_s),
        .full      (tx_full_s),
        .data      (tx_byte_s)
    );

    uart_byte_buf u_rx_buf (
        .CLK       (CLK),
        .Reset     (Reset),
        .load      (rx_load_s),
        .load_data (rdata[7:0]),
        .clear     (rx_pop_s),
        .full      (rx_full_s),
        .data      (rx_byte_s)
    );

    // Sequencer: each bus strobe is registered on entry to the state that owns it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ST_INIT;
            cnt_r   <= CNT_ZERO;
            rd      <= 1'b0;
            wr      <= 1'b0;
            addr    <= 32'h0000_0000;
            wdata   <= 32'h0000_0000;
            busy    <= 1'b0;
        end else begin
            rd <= 1'b0;
            wr <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    // First cycle after reset is idle; the CON write fills the second.
                    if (!wr) begin
                        wr    <= 1'b1;
                        addr  <= CON_ADDR;
                        wdata <= CON_INIT;
                        busy  <= 1'b1;
                    end else begin
                        state_r <= AFTER_OP;
                        cnt_r   <= GAP_LOAD;
                        rd      <= (AFTER_OP == ST_POLL);
                        addr    <= CON_ADDR;
                        busy    <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_POLL;
                        rd      <= 1'b1;
                        addr    <= CON_ADDR;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_POLL: begin
                    if (rdata[CON3_BIT] && !rx_full_s) begin
                        state_r <= ST_RX_RD;
                        rd      <= 1'b1;
                        addr    <= RXD_ADDR;
                        busy    <= 1'b1;
                    end else if (rdata[TX_STATUS_BIT] && tx_full_s) begin
                        state_r <= ST_TX_WR;
                        wr      <= 1'b1;
                        addr    <= TXD_ADDR;
                        wdata   <= {24'h00_0000, tx_byte_s};
                        busy    <= 1'b1;
                    end else begin
                        state_r <= AFTER_OP;
                        cnt_r   <= GAP_LOAD;
                        rd      <= (AFTER_OP == ST_POLL);
                        addr    <= CON_ADDR;
                        busy    <= 1'b0;
                    end
                end
                ST_RX_RD: begin
                    state_r <= AFTER_OP;
                    cnt_r   <= GAP_LOAD;
                    rd      <= (AFTER_OP == ST_POLL);
                    addr    <= CON_ADDR;
                    busy    <= 1'b0;
                end
                ST_TX_WR: begin
                    state_r <= ST_HOLD;
                    cnt_r   <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    // TX_STATUS must have fallen before CON is polled again.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= AFTER_OP;
                        cnt_r   <= GAP_LOAD;
                        rd      <= (AFTER_OP == ST_POLL);
                        addr    <= CON_ADDR;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench: uart_bus_master against a behavioural UART peripheral whose
// serial output is looped back to its receiver.
module tb_uart_bus_master;

    localparam logic [31:0] TXD_A = 32'h4000_0018;
    localparam logic [31:0] RXD_A = 32'h4000_001C;
    localparam logic [31:0] CON_A = 32'h4000_0020;
    localparam int HOLDOFF = 4;
    localparam int POLL_GAP = 15;
    localparam int BIT = 4;
    localparam int FRAME = 10 * BIT;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        rd, wr, tx_ready, rx_valid, busy;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b1;

    always #5 CLK = ~CLK;

    uart_bus_master #(.BASE_ADDR(TXD_A), .HOLDOFF(HOLDOFF), .POLL_GAP(POLL_GAP)) dut (
        .CLK(CLK), .Reset(Reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference streams: bytes offered for transmission, bytes the consumer must see.
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    // ---------------- behavioural UART peripheral ----------------
    logic       con1_p = 1'b0;
    logic       rx_flag_p = 1'b0;
    logic [7:0] rxd_p = 8'h00;
    logic [7:0] txb_p = 8'h00;
    int         tx_cnt_p = 0;
    logic       force_p = 1'b0;
    logic       tx_status_p, txd_p;
    int         bit_idx_p;

    always_comb begin
        tx_status_p = (tx_cnt_p < 2);
        txd_p = 1'b1;
        bit_idx_p = 0;
        if (tx_cnt_p >= 2 && tx_cnt_p < FRAME + 2) begin
            bit_idx_p = (tx_cnt_p - 2) / BIT;
            if (bit_idx_p == 0) txd_p = 1'b0;
            else if (bit_idx_p <= 8) txd_p = txb_p[bit_idx_p - 1];
            else txd_p = 1'b1;
        end
    end

    always_comb begin
        rdata = 32'h0000_0000;
        if (addr == CON_A) begin
            rdata[1] = con1_p;
            rdata[3] = rx_flag_p | force_p;
            rdata[4] = tx_status_p | force_p;
        end else if (addr == RXD_A) begin
            rdata[7:0] = rxd_p;
        end
    end

    always @(posedge CLK) begin
        if (wr && addr == CON_A) con1_p <= wdata[1];
        if (rd && addr == RXD_A) rx_flag_p <= 1'b0;
        if (wr && addr == TXD_A) begin
            txb_p <= wdata[7:0];
            tx_cnt_p <= 1;
        end else if (tx_cnt_p == FRAME + 2) begin
            tx_cnt_p <= 0;
            if (con1_p) begin
                rxd_p <= txb_p;
                rx_flag_p <= 1'b1;
                // An unread byte still in RXD is overwritten and lost.
                if (rx_flag_p && !(rd && addr == RXD_A) && exp_rx.size() > 0) void'(exp_rx.pop_back());
                exp_rx.push_back(txb_p);
            end
        end else if (tx_cnt_p != 0) begin
            tx_cnt_p <= tx_cnt_p + 1;
        end
    end

    // ---------------- bus / stream monitor ----------------
    typedef struct { int cyc; logic is_wr; logic [31:0] a; logic [31:0] d; } op_t;
    op_t ops[$];
    int cyc = 0;
    int last_cyc = 0;
    logic last_wr = 1'b0;
    logic [31:0] last_a = 32'h0;
    logic have_last = 1'b0;
    int exp_d;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (Reset) begin
            have_last = 1'b0;
        end else begin
            if (rd || wr) begin
                check("one_strobe", 32'(rd & wr), 32'd0);
                if (have_last) begin
                    if (last_wr && last_a == TXD_A) exp_d = HOLDOFF + POLL_GAP + 1;
                    else if (!last_wr && last_a == CON_A && ((rd && addr == RXD_A) || (wr && addr == TXD_A))) exp_d = 1;
                    else exp_d = POLL_GAP + 1;
                    check("op_spacing", 32'(cyc - last_cyc), 32'(exp_d));
                end
                if (wr && addr == TXD_A) begin
                    check("txd_while_tx_busy", 32'(tx_cnt_p), 32'd0);
                    if (exp_tx.size() > 0) check("txd_data", wdata, {24'h0, exp_tx.pop_front()});
                    else check("txd_spurious_count", 32'(exp_tx.size()), 32'd1);
                end
                ops.push_back('{cyc, wr, addr, wdata});
                have_last = 1'b1;
                last_cyc = cyc;
                last_wr = wr;
                last_a = addr;
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                else check("rx_spurious_count", 32'(exp_rx.size()), 32'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic rx_rand = 1'b0;

    task automatic step();
        @(posedge CLK);
        #1;
        if (rx_rand) rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic offer(input logic [7:0] b);
        int t;
        t = 0;
        tx_data = b;
        tx_valid = 1'b1;
        exp_tx.push_back(b);
        while (!tx_ready && t < 3000) begin step(); t++; end
        check("tx_accept", 32'(tx_ready), 32'd1);
        step();
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0 || tx_cnt_p != 0 || rx_valid) && t < 3000) begin
            step();
            t++;
        end
        check(tag, 32'(exp_tx.size() + exp_rx.size()), 32'd0);
    endtask

    function automatic int count_ops(input int from, input logic is_wr, input logic [31:0] a);
        int n;
        n = 0;
        for (int i = from; i < ops.size(); i++) if (ops[i].is_wr == is_wr && ops[i].a == a) n++;
        return n;
    endfunction

    task automatic expect_init_write(input string tag);
        int n0, t;
        n0 = ops.size();
        t = 0;
        while (ops.size() <= n0 && t < 100) begin step(); t++; end
        if (ops.size() > n0) begin
            check({tag, "_is_wr"}, 32'(ops[n0].is_wr), 32'd1);
            check({tag, "_addr"}, ops[n0].a, CON_A);
            check({tag, "_wdata"}, ops[n0].d, 32'h2);
        end else begin
            check({tag, "_timeout"}, 32'(ops.size()), 32'(n0 + 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, 32'(rd), 32'd0);
        check({tag, "_wr"}, 32'(wr), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int m, t;
        logic [9:0] frame;
        logic [7:0] b;

        // Reset held for three cycles.
        repeat (3) step();
        check_reset_outputs("reset");
        check("reset_addr", addr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        Reset = 1'b0;
        expect_init_write("init");

        // Single byte 0x55: one TXD write and the serial frame on the line.
        m = ops.size();
        offer(8'h55);
        t = 0;
        while (txd_p !== 1'b0 && t < 200) begin step(); t++; end
        frame = {1'b1, 8'h55, 1'b0};
        repeat (BIT / 2) step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("serial_bit%0d", i), 32'(txd_p), 32'(frame[i]));
            repeat (BIT) step();
        end
        drain("drain_55");
        check("txd_writes_55", 32'(count_ops(m, 1'b1, TXD_A)), 32'd1);

        // Loopback 0xA3 with consumer ready: one RXD read, rx_valid for one cycle.
        m = ops.size();
        offer(8'hA3);
        t = 0;
        while (!rx_valid && t < 300) begin step(); t++; end
        check("a3_rx_valid", 32'(rx_valid), 32'd1);
        check("a3_rx_data", 32'(rx_data), 32'hA3);
        step();
        check("a3_rx_valid_one_cycle", 32'(rx_valid), 32'd0);
        drain("drain_a3");
        check("a3_rxd_reads", 32'(count_ops(m, 1'b0, RXD_A)), 32'd1);

        // Consumer stalled: no RXD read while the RX register is full.
        rx_ready = 1'b0;
        m = ops.size();
        offer(8'h3C);
        t = 0;
        while (!rx_valid && t < 300) begin step(); t++; end
        offer(8'h5A);
        t = 0;
        while (!rx_flag_p && t < 300) begin step(); t++; end
        repeat (60) step();
        check("stall_rxd_reads", 32'(count_ops(m, 1'b0, RXD_A)), 32'd1);
        check("stall_rx_valid", 32'(rx_valid), 32'd1);
        check("stall_rx_data", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        drain("drain_stall");
        check("stall_rxd_reads_after", 32'(count_ops(m, 1'b0, RXD_A)), 32'd2);

        // Forced CON bits 3 and 4 with TX pending: RX read wins, TX write on next poll.
        t = 0;
        while (!(rd && addr == CON_A) && t < 100) begin step(); t++; end
        step();
        force_p = 1'b1;
        exp_rx.push_back(rxd_p);
        m = ops.size();
        offer(8'h96);
        t = 0;
        while (!(rd && addr == CON_A) && t < 100) begin step(); t++; end
        step();
        force_p = 1'b0;
        t = 0;
        while (ops.size() < m + 4 && t < 200) begin step(); t++; end
        if (ops.size() >= m + 4) begin
            check("force_op0_addr", ops[m].a, CON_A);
            check("force_op1_addr", ops[m + 1].a, RXD_A);
            check("force_op1_is_wr", 32'(ops[m + 1].is_wr), 32'd0);
            check("force_op2_addr", ops[m + 2].a, CON_A);
            check("force_op3_addr", ops[m + 3].a, TXD_A);
            check("force_op3_is_wr", 32'(ops[m + 3].is_wr), 32'd1);
        end else begin
            check("force_timeout", 32'(ops.size()), 32'(m + 4));
        end
        drain("drain_force");

        // Reset during HOLD with a second byte pending.
        offer(8'h11);
        tx_data = 8'h22;
        tx_valid = 1'b1;
        exp_tx.push_back(8'h22);
        t = 0;
        while (!tx_ready && t < 300) begin step(); t++; end
        step();
        tx_valid = 1'b0;
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_tx_pending", 32'(tx_ready), 32'd0);
        if (exp_tx.size() > 0) void'(exp_tx.pop_back());
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs($sformatf("midreset%0d", i));
        end
        Reset = 1'b0;
        expect_init_write("reinit");
        drain("drain_reset");

        // Random bytes with a randomly stalling consumer.
        rx_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 60)) step();
            b = 8'($urandom);
            offer(b);
        end
        rx_rand = 1'b0;
        rx_ready = 1'b1;
        drain("drain_random");
        check("final_tx_queue", 32'(exp_tx.size()), 32'd0);
        check("final_rx_queue", 32'(exp_rx.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
